// File: rtl/tmip_out_if.sv
// TMIP result stream as seen by the on-chip self-test harness.
// The master drives the stream (TMIP or a bench model); the collector is the slave.
interface tmip_out_if #(
    parameter int VAL_W = 40
) ();
    logic             out_valid;
    logic [3:0]       out_x;
    logic [3:0]       out_y;
    logic [7:0]       out_img_pos;
    logic [VAL_W-1:0] out_value;

    modport master (output out_valid, out_x, out_y, out_img_pos, out_value);
    modport slave  (input  out_valid, out_x, out_y, out_img_pos, out_value);
endinterface

// File: rtl/tmip_out_collector.sv
// Captures one TMIP output burst into a readback buffer and checks it against the
// stream protocol, latching the first violation.
//
//   state     | meaning
//   IDLE      | waiting for arm after reset
//   ARMED     | armed, counting latency until the first out_valid
//   CAPTURE   | storing beats until out_valid drops or an error occurs
//   DONE      | capture finished; results and buffer held for readback
module tmip_out_collector #(
    parameter int DEPTH   = 256,
    parameter int VAL_W   = 40,
    parameter int TIMEOUT = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [4:0]       exp_size,
    tmip_out_if.slave        tmip,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [3:0]       cap_x,
    output logic [3:0]       cap_y,
    output logic [8:0]       beat_cnt,
    output logic [13:0]      latency,
    input  logic [7:0]       rd_addr,
    output logic [VAL_W-1:0] rd_data,
    input  logic [3:0]       pos_idx,
    output logic [7:0]       pos_data
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // latency saturates, so the timeout is clamped to a value the counter can reach
    localparam int         TO_SAT  = (TIMEOUT > 16383) ? 16383 : TIMEOUT;
    localparam logic [13:0] TO_LIM = 14'(TO_SAT);

    logic [1:0]       state;
    logic [8:0]       n_sq;
    logic             size_ok;
    logic [8:0]       size_sq;
    logic             xy_bad;
    logic             pos_bad;
    logic             over;
    logic             idle_bad;
    logic [13:0]      lat_inc;
    logic             wr_en;
    logic             pos_we;

    logic [VAL_W-1:0] mem [0:DEPTH-1];
    logic [7:0]       pos_mem [0:8];

    always_comb begin
        size_ok = 1'b1;
        size_sq = 9'd0;
        case (exp_size)
            5'd4:    size_sq = 9'd16;
            5'd8:    size_sq = 9'd64;
            5'd16:   size_sq = 9'd256;
            default: size_ok = 1'b0;
        endcase
    end

    assign xy_bad   = (tmip.out_x != cap_x) || (tmip.out_y != cap_y);
    assign pos_bad  = (beat_cnt >= 9'd9) && (tmip.out_img_pos != 8'd0);
    assign over     = (beat_cnt == n_sq);
    assign idle_bad = (tmip.out_x != 4'd0) || (tmip.out_y != 4'd0) ||
                      (tmip.out_img_pos != 8'd0) || (|tmip.out_value);
    assign lat_inc  = (latency == 14'h3fff) ? latency : latency + 14'd1;
    assign busy     = (state == S_ARMED) || (state == S_CAPTURE);

    // beat_cnt is 0 in ARMED, so it doubles as the write address for beat 0
    assign wr_en  = !rst && tmip.out_valid &&
                    ((state == S_ARMED) || ((state == S_CAPTURE) && !over));
    assign pos_we = wr_en && (beat_cnt < 9'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 3'd0;
            cap_x    <= 4'd0;
            cap_y    <= 4'd0;
            beat_cnt <= 9'd0;
            latency  <= 14'd0;
            n_sq     <= 9'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        err      <= 1'b0;
                        err_code <= 3'd0;
                        beat_cnt <= 9'd0;
                        latency  <= 14'd0;
                        cap_x    <= 4'd0;
                        cap_y    <= 4'd0;
                        n_sq     <= size_sq;
                        if (!size_ok) begin
                            err      <= 1'b1;
                            err_code <= 3'd1;
                            state    <= S_DONE;
                            done     <= ~done;
                        end else begin
                            state <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (tmip.out_valid) begin
                        cap_x    <= tmip.out_x;
                        cap_y    <= tmip.out_y;
                        beat_cnt <= 9'd1;
                        state    <= S_CAPTURE;
                    end else if (idle_bad) begin
                        err      <= 1'b1;
                        err_code <= 3'd2;
                        state    <= S_DONE;
                        done     <= 1'b1;
                    end else begin
                        latency <= lat_inc;
                        if (lat_inc == TO_LIM) begin
                            err      <= 1'b1;
                            err_code <= 3'd3;
                            state    <= S_DONE;
                            done     <= 1'b1;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (tmip.out_valid) begin
                        if (over) begin
                            err      <= 1'b1;
                            err_code <= 3'd5;
                            state    <= S_DONE;
                            done     <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                            if (xy_bad || pos_bad) begin
                                err      <= 1'b1;
                                err_code <= xy_bad ? 3'd6 : 3'd7;
                                state    <= S_DONE;
                                done     <= 1'b1;
                            end
                        end
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        if (beat_cnt < n_sq) begin
                            err      <= 1'b1;
                            err_code <= 3'd4;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[beat_cnt[7:0]] <= tmip.out_value;
        if (pos_we)
            pos_mem[beat_cnt[3:0]] <= tmip.out_img_pos;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            pos_data <= 8'd0;
        end else begin
            rd_data  <= mem[rd_addr];
            pos_data <= (pos_idx <= 4'd8) ? pos_mem[pos_idx] : 8'd0;
        end
    end
endmodule

// File: tb/tb_tmip_out_collector.sv
// Directed bench for tmip_out_collector: driven beats go into a scoreboard queue
// and are popped against the readback buffer once each capture ends.
module tb_tmip_out_collector;
    localparam int VAL_W = 40;

    logic             clk;
    logic             rst;
    logic             arm;
    logic [4:0]       exp_size;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       err_code;
    logic [3:0]       cap_x;
    logic [3:0]       cap_y;
    logic [8:0]       beat_cnt;
    logic [13:0]      latency;
    logic [7:0]       rd_addr;
    logic [VAL_W-1:0] rd_data;
    logic [3:0]       pos_idx;
    logic [7:0]       pos_data;

    tmip_out_if #(.VAL_W(VAL_W)) tif ();

    tmip_out_collector #(.DEPTH(256), .VAL_W(VAL_W), .TIMEOUT(10000)) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .exp_size (exp_size),
        .tmip     (tif),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .cap_x    (cap_x),
        .cap_y    (cap_y),
        .beat_cnt (beat_cnt),
        .latency  (latency),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .pos_idx  (pos_idx),
        .pos_data (pos_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [VAL_W-1:0] sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        tif.out_valid   = 1'b0;
        tif.out_x       = 4'd0;
        tif.out_y       = 4'd0;
        tif.out_img_pos = 8'd0;
        tif.out_value   = '0;
    endtask

    task automatic do_arm(input logic [4:0] n);
        arm      = 1'b1;
        exp_size = n;
        tick();
        arm = 1'b0;
    endtask

    task automatic beat(input logic [VAL_W-1:0] v, input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] p, input bit push);
        tif.out_valid   = 1'b1;
        tif.out_x       = x;
        tif.out_y       = y;
        tif.out_img_pos = p;
        tif.out_value   = v;
        if (push) sb.push_back(v);
        tick();
    endtask

    task automatic drain_sb(input string tag);
        logic [VAL_W-1:0] e;
        int i;
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = i[7:0];
            tick();
            check(tag, rd_data, e);
            i++;
        end
    endtask

    initial begin
        logic [VAL_W-1:0] v;
        logic [7:0] p;
        int cnt;

        rst = 1'b1; arm = 1'b0; exp_size = 5'd0; rd_addr = 8'd0; pos_idx = 4'd0;
        bus_idle();
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_code", err_code, 0);
        check("rst_cnt", beat_cnt, 0);
        check("rst_lat", latency, 0);
        check("rst_rd", rd_data, 0);
        check("rst_pos", pos_data, 0);
        rst = 1'b0;
        tick();

        // N=4, 5 idle cycles, values -8..7
        do_arm(5'd4);
        check("t1_busy", busy, 1);
        repeat (5) tick();
        for (int i = 0; i < 16; i++) begin
            v = VAL_W'(i - 8);
            p = (i == 1) ? 8'd1 : (i == 2) ? 8'd4 : (i == 3) ? 8'd5 : 8'd0;
            beat(v, 4'd2, 4'd1, p, 1'b1);
        end
        check("t1_done_early", done, 0);
        bus_idle();
        tick();
        check("t1_done", done, 1);
        check("t1_busy_fall", busy, 0);
        check("t1_err", err, 0);
        check("t1_cnt", beat_cnt, 16);
        check("t1_lat", latency, 5);
        check("t1_capx", cap_x, 2);
        check("t1_capy", cap_y, 1);
        tick();
        check("t1_done_pulse", done, 0);
        rd_addr = 8'd3; tick();
        check("t1_rd3", rd_data, 64'(40'hff_ffff_fffb));
        pos_idx = 4'd2; tick();
        check("t1_pos2", pos_data, 4);
        pos_idx = 4'd1; tick();
        check("t1_pos1", pos_data, 1);
        drain_sb("t1_sb");

        // N=16, 256 beats of 2^38, beat 0 on the first ARMED cycle
        do_arm(5'd16);
        for (int i = 0; i < 256; i++) beat(40'h40_0000_0000, 4'd3, 4'd7, 8'd0, 1'b1);
        check("t2_done_early", done, 0);
        bus_idle();
        tick();
        check("t2_done", done, 1);
        check("t2_err", err, 0);
        check("t2_lat", latency, 0);
        check("t2_cnt", beat_cnt, 256);
        tick();
        check("t2_done_pulse", done, 0);
        rd_addr = 8'd255; tick();
        check("t2_rd255", rd_data, 64'(40'h40_0000_0000));
        drain_sb("t2_sb");

        // N=8 short (63 beats)
        do_arm(5'd8);
        for (int i = 0; i < 63; i++) beat(VAL_W'(1000 + 3 * i), 4'd1, 4'd1, 8'd0, 1'b1);
        bus_idle();
        tick();
        check("t3_done", done, 1);
        check("t3_err", err, 1);
        check("t3_code", err_code, 4);
        check("t3_cnt", beat_cnt, 63);
        drain_sb("t3_sb");

        // N=8 long (65 beats): the 65th raises error 5 and is not stored
        do_arm(5'd8);
        for (int i = 0; i < 64; i++) beat(VAL_W'(77 * i + 5), 4'd4, 4'd5, 8'd0, 1'b1);
        check("t3b_done_early", done, 0);
        beat(40'h12_3456_789a, 4'd4, 4'd5, 8'd0, 1'b0);
        check("t3b_done", done, 1);
        check("t3b_code", err_code, 5);
        check("t3b_cnt", beat_cnt, 64);
        bus_idle();
        tick();
        check("t3b_code_hold", err_code, 5);
        drain_sb("t3b_sb");

        // idle-nonzero in ARMED
        do_arm(5'd8);
        tick(); tick();
        tif.out_value = 40'd1;
        tick();
        check("t4_done", done, 1);
        check("t4_err", err, 1);
        check("t4_code", err_code, 2);
        bus_idle();
        tick();

        // timeout with TMIP silent
        do_arm(5'd8);
        cnt = 0;
        while (!done && cnt < 10100) begin
            tick();
            cnt++;
        end
        check("t4b_to_cycles", cnt, 10000);
        check("t4b_code", err_code, 3);
        check("t4b_busy", busy, 0);

        // x change on beat 6, later pos nonzero after error is ignored
        do_arm(5'd4);
        for (int i = 0; i < 6; i++) beat(VAL_W'(i), 4'd2, 4'd2, 8'd0, 1'b0);
        check("t5_done_early", done, 0);
        beat(40'd6, 4'd3, 4'd2, 8'd0, 1'b0);
        check("t5_done", done, 1);
        check("t5_code", err_code, 6);
        for (int i = 7; i < 11; i++) beat(VAL_W'(i), 4'd2, 4'd2, (i == 10) ? 8'd9 : 8'd0, 1'b0);
        check("t5_code_hold", err_code, 6);
        check("t5_done_after", done, 0);
        bus_idle();
        tick();

        // bad size
        do_arm(5'd5);
        check("t5b_done", done, 1);
        check("t5b_code", err_code, 1);
        check("t5b_busy", busy, 0);
        tick();
        check("t5b_done_pulse", done, 0);

        // pos after beat 8 on an otherwise clean stream
        do_arm(5'd4);
        for (int i = 0; i < 9; i++) beat(VAL_W'(i), 4'd0, 4'd0, 8'd0, 1'b0);
        beat(40'd9, 4'd0, 4'd0, 8'd9, 1'b0);
        check("t5c_code", err_code, 7);
        bus_idle();
        tick();

        // reset on beat 20 of N=16
        do_arm(5'd16);
        for (int i = 0; i < 20; i++) beat(VAL_W'(i + 500), 4'd6, 4'd6, 8'd3, 1'b0);
        rst = 1'b1;
        beat(40'd520, 4'd6, 4'd6, 8'd0, 1'b0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_err", err, 0);
        check("t6_code", err_code, 0);
        check("t6_capx", {cap_x, cap_y}, 0);
        check("t6_cnt", beat_cnt, 0);
        check("t6_lat", latency, 0);
        check("t6_rd", rd_data, 0);
        check("t6_pos", pos_data, 0);
        rst = 1'b0;
        bus_idle();
        tick();
        check("t6_no_done", done, 0);

        do_arm(5'd4);
        tick();
        for (int i = 0; i < 16; i++) beat(VAL_W'(40'hff_0000_0000 + i), 4'd9, 4'd8, 8'd0, 1'b1);
        bus_idle();
        tick();
        check("t6b_done", done, 1);
        check("t6b_err", err, 0);
        check("t6b_cnt", beat_cnt, 16);
        check("t6b_lat", latency, 1);
        drain_sb("t6b_sb");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
